wb_b4_req_master: RTL and testbench

- Single-outstanding Wishbone B4 pipelined bus master. It sits directly upstream of the UART Wishbone slave port.
- It converts a simple valid/ready register-access request (read or write) into one B4 pipelined cycle, honouring stall and ack.
- It returns read data, or a timeout error, as a one-cycle response pulse.
- The UVM wishbone agent's driver and the top-level register sequencer harness use it.

---
 rtl/wb_b4_req_master_if.sv | 38 +++
 rtl/wb_b4_req_master.sv | 177 +++++++++++++++++
 tb/tb_wb_b4_req_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_b4_req_master_if.sv
// rtl/wb_b4_req_master_if.sv - Wishbone B4 pipelined bus bundle
//
// Purpose: groups the Wishbone B4 pipelined signals between one master and one slave.
// Signals:
//   wb_cyc, wb_stb, wb_we  master -> slave cycle, strobe and write enable
//   wb_addr, wb_sel        master -> slave address and byte selects
//   wb_data_o              master -> slave write data
//   wb_stall, wb_ack       slave -> master stall and acknowledge
//   wb_data_i              slave -> master read data
// Modports: master drives the request side; slave drives stall/ack/read data.

interface wb_b4_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [SEL_WIDTH-1:0]  wb_sel;
  logic                  wb_stall;
  logic                  wb_ack;
  logic [DATA_WIDTH-1:0] wb_data_i;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_data_o, wb_sel,
    input  wb_stall, wb_ack, wb_data_i
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_data_o, wb_sel,
    output wb_stall, wb_ack, wb_data_i
  );

endinterface

// File: rtl/wb_b4_req_master.sv
// rtl/wb_b4_req_master.sv - single-outstanding Wishbone B4 pipelined request master
//
// Purpose: turns one valid/ready register-access request into one B4 pipelined
// bus cycle and returns a one-cycle response pulse carrying read data or a
// timeout error. Every output is driven straight from a register.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_addr,
//   req_wdata, req_sel       request contents
//   rsp_valid                one-cycle response pulse
//   rsp_rdata, rsp_err       response payload, held until the next response
//   wb                       Wishbone B4 pipelined master modport

module wb_b4_req_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [SEL_WIDTH-1:0]  req_sel,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  wb_b4_req_master_if.master    wb
);

  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  complete;
  logic                  timeout_hit;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    complete    = 1'b0;

    // Timer counts cycles with cyc high and sticks at all-ones.
    if (cyc_q && (timer_q != {TW{1'b1}})) begin
      timer_d = timer_q + 1'b1;
    end
    timeout_hit = TO_EN && cyc_q && (timer_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          sel_d       = req_sel;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          timer_d     = '0;
          req_ready_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // An ack while stalled is a slave protocol violation and is dropped.
        if (!wb.wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT;
          if (wb.wb_ack) begin
            complete = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wb.wb_ack) begin
          complete = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ack takes priority over a timeout landing on the same edge.
    if (complete) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      state_d     = IDLE;
      req_ready_d = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = we_q ? '0 : wb.wb_data_i;
      rsp_err_d   = 1'b0;
    end else if (timeout_hit) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      state_d     = IDLE;
      req_ready_d = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign wb.wb_cyc    = cyc_q;
  assign wb.wb_stb    = stb_q;
  assign wb.wb_we     = we_q;
  assign wb.wb_addr   = addr_q;
  assign wb.wb_data_o = wdata_q;
  assign wb.wb_sel    = sel_q;

endmodule

// File: tb/tb_wb_b4_req_master.sv
// tb/tb_wb_b4_req_master.sv - directed scoreboard bench for wb_b4_req_master

module tb_wb_b4_req_master;

  localparam int AW = 32;
  localparam int SW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_sel;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  wb_b4_req_master_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) wb_if ();

  wb_b4_req_master #(
    .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb(wb_if)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   stb_cnt = 0;
  int   rsp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] rdata, input logic err);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    cyc_cnt = 0;
    stb_cnt = 0;
    rsp_cnt = 0;
  endtask

  // Advance one edge, then sample away from it and score any response.
  task automatic cycle();
    rsp_t e;
    @(posedge clk);
    #1;
    if (wb_if.wb_cyc === 1'b1) cyc_cnt++;
    if (wb_if.wb_stb === 1'b1) stb_cnt++;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_sel   = '0;
    wb_if.wb_stall  = 1'b0;
    wb_if.wb_ack    = 1'b0;
    wb_if.wb_data_i = '0;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_cyc", 64'(wb_if.wb_cyc), 64'd0);
    check("rst_stb", 64'(wb_if.wb_stb), 64'd0);
    check("rst_we", 64'(wb_if.wb_we), 64'd0);
    check("rst_addr", 64'(wb_if.wb_addr), 64'd0);
    check("rst_data_o", 64'(wb_if.wb_data_o), 64'd0);
    check("rst_sel", 64'(wb_if.wb_sel), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    cycle();

    // 1: write, no stall, ack one cycle after strobe acceptance
    clr();
    push_exp(32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'hA5; req_sel = 4'hF;
    cycle();
    check("t1_stb", 64'(wb_if.wb_stb), 64'd1);
    check("t1_we", 64'(wb_if.wb_we), 64'd1);
    check("t1_data_o", 64'(wb_if.wb_data_o), 64'hA5);
    check("t1_addr", 64'(wb_if.wb_addr), 64'h4);
    check("t1_ready_busy", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    cycle();
    wb_if.wb_ack = 1'b1;
    cycle();
    wb_if.wb_ack = 1'b0;
    check("t1_rsp_latency", 64'(rsp_valid), 64'd1);
    cycle();
    cycle();
    check("t1_stb_cycles", 64'(stb_cnt), 64'd1);
    check("t1_cyc_cycles", 64'(cyc_cnt), 64'd2);
    check("t1_rsp_count", 64'(rsp_cnt), 64'd1);

    // 2: read with three stalled edges; an ack while stalled must be ignored
    clr();
    push_exp(32'h12345678, 1'b0);
    wb_if.wb_stall = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_sel = 4'hF;
    cycle();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) begin
      check("t2_stb_held", 64'(wb_if.wb_stb), 64'd1);
      check("t2_addr_stable", 64'(wb_if.wb_addr), 64'h8);
      wb_if.wb_ack    = (i == 1);
      wb_if.wb_data_i = 32'hDEADBEEF;
      if (i == 3) wb_if.wb_stall = 1'b0;
      cycle();
    end
    check("t2_wait_stb", 64'(wb_if.wb_stb), 64'd0);
    check("t2_wait_cyc", 64'(wb_if.wb_cyc), 64'd1);
    wb_if.wb_ack = 1'b1; wb_if.wb_data_i = 32'h12345678;
    cycle();
    wb_if.wb_ack = 1'b0;
    cycle();
    check("t2_stb_cycles", 64'(stb_cnt), 64'd4);
    check("t2_rsp_count", 64'(rsp_cnt), 64'd1);

    // 3: timeout, slave never acks
    clr();
    push_exp(32'h0, 1'b1);
    wb_if.wb_data_i = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hC;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 30 && rsp_cnt == 0; i++) cycle();
    check("t3_rsp_seen", 64'(rsp_cnt), 64'd1);
    check("t3_cyc_cycles", 64'(cyc_cnt), 64'd8);
    check("t3_cyc_low", 64'(wb_if.wb_cyc), 64'd0);
    check("t3_stb_low", 64'(wb_if.wb_stb), 64'd0);
    check("t3_ready", 64'(req_ready), 64'd1);
    cycle();

    // 3b: ack on the same edge the timeout would fire; ack wins
    clr();
    push_exp(32'h600DF00D, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    wb_if.wb_ack = 1'b1; wb_if.wb_data_i = 32'h600DF00D;
    cycle();
    wb_if.wb_ack = 1'b0;
    check("t3b_rsp_count", 64'(rsp_cnt), 64'd1);
    check("t3b_cyc_cycles", 64'(cyc_cnt), 64'd8);
    cycle();

    // 4: back-to-back writes with req_valid held
    clr();
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_0001; req_sel = 4'h3;
    cycle();
    req_addr = 32'h24; req_wdata = 32'h2222_0002; req_sel = 4'hC;
    cycle();
    wb_if.wb_ack = 1'b1;
    cycle();
    wb_if.wb_ack = 1'b0;
    check("t4_rsp1", 64'(rsp_valid), 64'd1);
    check("t4_ready_in_rsp", 64'(req_ready), 64'd1);
    check("t4_gap_cyc_low", 64'(wb_if.wb_cyc), 64'd0);
    cycle();
    req_valid = 1'b0;
    check("t4_second_cyc", 64'(wb_if.wb_cyc), 64'd1);
    check("t4_second_stb", 64'(wb_if.wb_stb), 64'd1);
    check("t4_second_addr", 64'(wb_if.wb_addr), 64'h24);
    check("t4_second_data", 64'(wb_if.wb_data_o), 64'h2222_0002);
    check("t4_second_sel", 64'(wb_if.wb_sel), 64'hC);
    cycle();
    wb_if.wb_ack = 1'b1;
    cycle();
    wb_if.wb_ack = 1'b0;
    cycle();
    check("t4_rsp_count", 64'(rsp_cnt), 64'd2);

    // 5: reset while in WAIT; no response, ack in IDLE ignored
    clr();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h5A;
    cycle();
    req_valid = 1'b0;
    cycle();
    check("t5_in_wait", 64'({wb_if.wb_cyc, wb_if.wb_stb}), 64'b10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_cyc_drop", 64'(wb_if.wb_cyc), 64'd0);
    check("t5_stb_drop", 64'(wb_if.wb_stb), 64'd0);
    check("t5_ready", 64'(req_ready), 64'd1);
    wb_if.wb_ack = 1'b1; wb_if.wb_data_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) cycle();
    wb_if.wb_ack = 1'b0;
    cycle();
    check("t5_no_rsp", 64'(rsp_cnt), 64'd0);

    // 6: stall released and ack on the same REQ edge
    clr();
    push_exp(32'hCAFEF00D, 1'b0);
    wb_if.wb_stall = 1'b0; wb_if.wb_ack = 1'b1; wb_if.wb_data_i = 32'hCAFEF00D;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    cycle();
    req_valid = 1'b0;
    cycle();
    wb_if.wb_ack = 1'b0; wb_if.wb_data_i = 32'h0;
    check("t6_rsp", 64'(rsp_valid), 64'd1);
    check("t6_stb_cycles", 64'(stb_cnt), 64'd1);
    check("t6_cyc_cycles", 64'(cyc_cnt), 64'd1);
    cycle();
    cycle();
    check("t6_rdata_hold", 64'(rsp_rdata), 64'hCAFEF00D);
    check("t6_pulse_once", 64'(rsp_cnt), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
